// File: rtl/apb_regfile_bridge.sv
// apb_regfile_bridge: APB3 slave to DSP register-file request bridge with range check and response timeout (clk, async active-low rst; APB psel/penable/pwrite/paddr/pwdata -> prdata/pready/pslverr; rf_rd0_wr1/rf_valid/rf_addr/rf_wdata out, rf_rd_data/rf_rd_valid/rf_ready in; APB_BRIDGE_ERR_CNT_EN adds err_clr in, err_count out)
module apb_regfile_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_FILE_DEPTH = 26,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  rf_rd0_wr1,
  output logic                  rf_valid,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  input  logic                  rf_ready
`ifdef APB_BRIDGE_ERR_CNT_EN
  ,
  input  logic                  err_clr,
  output logic [7:0]            err_count
`endif
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic err, err_n, wr_n, expired, oor;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n, prdata_n;
  assign expired  = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign oor      = paddr >= ADDR_WIDTH'(REG_FILE_DEPTH);
  assign pready   = state == DONE;
  assign pslverr  = pready && err;
  assign rf_valid = state == ISSUE && rf_ready;
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    err_n    = err;
    wr_n     = rf_rd0_wr1;
    addr_n   = rf_addr;
    wdata_n  = rf_wdata;
    prdata_n = prdata;
    case (state)
      IDLE: if (psel && !penable) begin
        addr_n  = paddr;
        wdata_n = pwdata;
        wr_n    = pwrite;
        cnt_n   = '0;
        err_n   = oor;
        state_n = oor ? DONE : ISSUE;
      end
      ISSUE: if (rf_ready) begin
        cnt_n   = '0;
        state_n = rf_rd0_wr1 ? DONE : WAIT_RD;
      end else begin
        cnt_n   = cnt + CW'(1);
        err_n   = expired;
        state_n = expired ? DONE : ISSUE;
      end
      WAIT_RD: if (rf_rd_valid) begin
        prdata_n = rf_rd_data;
        state_n  = DONE;
      end else begin
        cnt_n    = cnt + CW'(1);
        err_n    = expired;
        prdata_n = expired ? '0 : prdata;
        state_n  = expired ? DONE : WAIT_RD;
      end
      DONE: if (!psel || penable) begin
        err_n   = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      err        <= 1'b0;
      rf_rd0_wr1 <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
      prdata     <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      err        <= err_n;
      rf_rd0_wr1 <= wr_n;
      rf_addr    <= addr_n;
      rf_wdata   <= wdata_n;
      prdata     <= prdata_n;
    end
`ifdef APB_BRIDGE_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) err_count <= '0;
    else if (err_clr) err_count <= '0;
    else if (pslverr && psel && penable && err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
endmodule

// File: tb/tb_apb_regfile_bridge.sv
// tb_apb_regfile_bridge: randomized scoreboard bench for apb_regfile_bridge with a register-file responder model
module tb_apb_regfile_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 26;
  localparam int TO = 16;
  logic clk = 0, rst = 0;
  logic psel = 0, penable = 0, pwrite = 0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [DW-1:0] prdata;
  logic pready, pslverr, rf_rd0_wr1, rf_valid;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rd_data = '0;
  logic rf_rd_valid = 0, rf_ready = 1;
`ifdef APB_BRIDGE_ERR_CNT_EN
  logic err_clr = 0;
  logic [7:0] err_count;
  int exp_errcnt = 0;
`endif
  apb_regfile_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_FILE_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .rf_rd0_wr1(rf_rd0_wr1), .rf_valid(rf_valid),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .rf_ready(rf_ready)
`ifdef APB_BRIDGE_ERR_CNT_EN
    , .err_clr(err_clr), .err_count(err_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic err; logic [DW-1:0] data; int lat;} rsp_t;
  typedef struct {logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata;} req_t;
  rsp_t exp_q[$];
  req_t req_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] rf_mem [DEPTH];
  logic [DW-1:0] last_prdata = '0;
  int checks = 0, errors = 0, cyc = 0, start = 0;
  bit rd_hang = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  rsp_t m_e;
  req_t m_r;
  always @(negedge clk) begin
    if (psel && !penable) start = cyc;
    if (rf_valid) begin
      if (req_q.size() == 0) chk("rf_valid_unexpected", 64'(rf_valid), 64'(0));
      else begin
        m_r = req_q.pop_front();
        chk("rf_dir", 64'(rf_rd0_wr1), 64'(m_r.wr));
        chk("rf_addr", 64'(rf_addr), 64'(m_r.addr));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_r.wdata));
      end
    end
    if (psel && penable && pready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'(pready), 64'(0));
      else begin
        m_e = exp_q.pop_front();
        chk("pslverr", 64'(pslverr), 64'(m_e.err));
        chk("prdata", 64'(prdata), 64'(m_e.data));
        chk("latency", 64'(cyc - start - 1), 64'(m_e.lat));
      end
    end
  end
  logic [AW-1:0] rd_addr;
  always begin
    @(negedge clk);
    if (rf_valid) begin
      if (rf_rd0_wr1) rf_mem[rf_addr] = rf_wdata;
      else if (!rd_hang) begin
        rd_addr = rf_addr;
        @(posedge clk); #1;
        rf_rd_data = rf_mem[rd_addr];
        rf_rd_valid = 1;
        @(posedge clk); #1;
        rf_rd_valid = 0;
        rf_rd_data = $urandom;
      end
    end
  end
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int stall);
    int lat;
    rf_ready = (stall == 0);
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    lat = 0;
    while (!pready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      rf_ready = (lat >= stall);
    end
    if (!pready) chk("pready_timeout", 64'(pready), 64'(1));
    else begin
      @(posedge clk); #1;
    end
    psel = 0; penable = 0; rf_ready = 1;
  endtask
  task automatic run(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int stall);
    rsp_t e;
    req_t r;
    bit oor, ito, rto;
    oor = a >= AW'(DEPTH);
    ito = !oor && stall >= TO;
    rto = !oor && !ito && !w && rd_hang;
    e.err = oor || ito || rto;
    e.lat = oor ? 0 : ito ? TO : stall + (w ? 1 : rto ? 1 + TO : 2);
    if (!oor && !ito) begin
      r.wr = w; r.addr = a; r.wdata = d;
      req_q.push_back(r);
      if (w) ref_mem[a] = d;
      else last_prdata = rto ? '0 : ref_mem[a];
    end
    e.data = last_prdata;
    exp_q.push_back(e);
`ifdef APB_BRIDGE_ERR_CNT_EN
    if (e.err && exp_errcnt < 255) exp_errcnt++;
`endif
    xfer(w, a, d, stall);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    req_t r;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = $urandom;
      rf_mem[i] = ref_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", 64'(prdata), 64'(0));
    chk("rst_pready", 64'(pready), 64'(0));
    chk("rst_pslverr", 64'(pslverr), 64'(0));
    chk("rst_rf_valid", 64'(rf_valid), 64'(0));
    chk("rst_rf_rd0_wr1", 64'(rf_rd0_wr1), 64'(0));
    chk("rst_rf_addr", 64'(rf_addr), 64'(0));
    chk("rst_rf_wdata", 64'(rf_wdata), 64'(0));
    rst = 1;
    @(posedge clk); #1;
    run(1, 8, 32'hA5, 0);
    run(1, 4, 32'hF, 0);
    run(0, 4, $urandom, 0);
    run(0, 26, $urandom, 0);
    run(0, 25, $urandom, 0);
    run(1, 32'hFFFF_FFFF, $urandom, 0);
    run(1, 3, $urandom, 5);
    run(0, 3, $urandom, 15);
    run(1, 7, $urandom, 16);
    rd_hang = 1;
    run(0, 10, $urandom, 0);
    rd_hang = 0;
    rf_rd_data = $urandom;
    rf_rd_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    rf_rd_valid = 0;
    run(1, 9, $urandom, 0);
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? AW'(DEPTH + $urandom_range(0, 1000)) : AW'($urandom_range(0, DEPTH - 1));
      run(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
    end
    rd_hang = 1;
    r.wr = 0; r.addr = 5; r.wdata = 32'h1234;
    req_q.push_back(r);
    psel = 1; penable = 0; pwrite = 0; paddr = 5; pwdata = 32'h1234;
    @(posedge clk); #1;
    penable = 1;
    repeat (4) @(posedge clk);
    #2;
    rst = 0;
    #1;
    chk("midrst_prdata", 64'(prdata), 64'(0));
    chk("midrst_pready", 64'(pready), 64'(0));
    chk("midrst_pslverr", 64'(pslverr), 64'(0));
    chk("midrst_rf_valid", 64'(rf_valid), 64'(0));
    chk("midrst_rf_addr", 64'(rf_addr), 64'(0));
    chk("midrst_rf_wdata", 64'(rf_wdata), 64'(0));
    chk("midrst_rf_rd0_wr1", 64'(rf_rd0_wr1), 64'(0));
    psel = 0; penable = 0;
    last_prdata = '0;
`ifdef APB_BRIDGE_ERR_CNT_EN
    chk("midrst_err_count", 64'(err_count), 64'(0));
    exp_errcnt = 0;
`endif
    @(posedge clk); #1;
    rst = 1;
    rd_hang = 0;
    @(posedge clk); #1;
    run(0, 40, $urandom, 0);
    run(1, 26, $urandom, 0);
    run(0, 32'h8000_0000, $urandom, 0);
    run(0, 12, $urandom, 1);
`ifdef APB_BRIDGE_ERR_CNT_EN
    chk("err_count", 64'(err_count), 64'(exp_errcnt));
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    chk("err_count_clr", 64'(err_count), 64'(0));
`endif
    repeat (4) @(posedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    chk("req_q_drained", 64'(req_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_regfile_bridge.md
Name: apb_regfile_bridge

Overview:
- APB3 slave that converts host APB transfers into the single-cycle valid/read-write request protocol of the DSP register file, and returns read data and errors to the host.
- Sits directly upstream of the register file: drives its rd/wr, valid, address and data inputs, and consumes its read data, read-valid and ready outputs.
- Adds address range checking and a read-response timeout so a stalled register file cannot hang the APB bus.

Parameters:
- DATA_WIDTH, 32, width of APB data and register-file data.
- ADDR_WIDTH, 32, width of APB address and register-file address.
- REG_FILE_DEPTH, 26, number of register-file entries; legal addresses are 0..REG_FILE_DEPTH-1.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for rf_ready or rf_rd_valid before signalling an error; must be >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  APB direction; 1 = write.
- paddr  in  ADDR_WIDTH  APB address; used directly as the register index.
- pwdata  in  DATA_WIDTH  APB write data.
- prdata  out  DATA_WIDTH  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error, valid only when pready=1.
- rf_rd0_wr1  out  1  register-file direction.
- rf_valid  out  1  register-file request strobe, one cycle per request.
- rf_addr  out  ADDR_WIDTH  register-file address.
- rf_wdata  out  DATA_WIDTH  register-file write data.
- rf_rd_data  in  DATA_WIDTH  register-file read data.
- rf_rd_valid  in  1  register-file read-data valid.
- rf_ready  in  1  register file can accept a request.

Behaviour:
- Reset is asynchronous, active-low, on rst; clock is clk.
- Reset values: prdata=0, pready=0, pslverr=0, rf_valid=0, rf_rd0_wr1=0, rf_addr=0, rf_wdata=0, FSM=IDLE, timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - On psel=1 and penable=0 (setup phase), latch paddr, pwdata and pwrite into rf_addr, rf_wdata and rf_rd0_wr1.
  - If paddr >= REG_FILE_DEPTH, go to DONE with error flag set and no register-file request.
  - Otherwise go to ISSUE and clear the timeout counter.
- ISSUE:
  - If rf_ready=1, assert rf_valid for exactly one cycle. Writes then go to DONE; reads go to WAIT_RD with the counter cleared.
  - If rf_ready=0, hold with rf_valid=0 and increment the counter. When the counter reaches TIMEOUT_CYCLES-1, go to DONE with the error flag set.
- WAIT_RD:
  - On rf_rd_valid=1, capture rf_rd_data into prdata and go to DONE. Capture takes priority over a timeout in the same cycle.
  - Otherwise increment the counter. On expiry go to DONE with error, and set prdata=0.
- DONE:
  - Drive pready=1 and pslverr=error flag.
  - When psel=1 and penable=1, the transfer completes: go to IDLE, and on the next cycle pready=0 and the error flag is cleared.
  - If psel drops before completion (protocol violation), return to IDLE and discard the transfer.
- pready=0 in every state except DONE, so any APB access phase extends until the bridge reaches DONE.
- Latency with setup sampled at cycle T and rf_ready=1:
  - rf_valid high at T+1.
  - Write: pready=1 at T+2.
  - Read, with rf_rd_valid at T+2: prdata valid and pready=1 at T+3.
- prdata holds its last value between reads; a write never modifies prdata.
- A stray rf_rd_valid in IDLE, ISSUE or DONE is ignored.
- No pipelining: only one outstanding request. New setup phases are sampled only in IDLE.
- Address arithmetic: unsigned comparison at full ADDR_WIDTH; no alignment check and no byte lanes.
- Reset mid-transfer: the FSM returns to IDLE immediately and rf_valid drops asynchronously. The host must restart the APB transfer.

Optional Feature:
- Macro: APB_BRIDGE_ERR_CNT_EN.
- When defined:
  - Adds output err_count [7:0]. It increments when a DONE-with-error transfer completes and saturates at 255.
  - Adds input err_clr (1 bit), which synchronously clears err_count to 0. If a clear and an increment fall in the same cycle, the clear wins.
  - err_count resets to 0.
- When undefined: neither port exists, and there is no counter logic.

Test Plan:
- Write: APB write to paddr=8 with pwdata=0x000000A5 and rf_ready=1 -> rf_valid one cycle at T+1 with rf_rd0_wr1=1, rf_addr=8, rf_wdata=0xA5; pready=1 and pslverr=0 at T+2.
- Read: APB read of paddr=4, with the model returning rf_rd_data=0x0000000F one cycle after rf_valid -> prdata=0x0000000F, pready=1 and pslverr=0 at T+3.
- Out-of-range: APB read of paddr=26 -> rf_valid never asserts; pready=1, pslverr=1 at T+1; prdata unchanged.
- Read timeout: APB read with rf_rd_valid held 0 and TIMEOUT_CYCLES=16 -> pslverr=1 and prdata=0 after 16 WAIT_RD cycles.
- Ready stall: rf_ready=0 for 5 cycles, then 1 -> rf_valid asserts on the first ready cycle, pslverr=0.
- Reset and optional counter: assert rst during WAIT_RD -> all outputs return to reset values. With APB_BRIDGE_ERR_CNT_EN, three error transfers give err_count=3, and err_clr then gives 0.
